// File: rtl/cpu_trace_probe.sv
`timescale 1ns/1ps
// Retire-trace capture: circular buffer of committed instructions, PC-match trigger with
// a post-trigger window, then an oldest-first valid/ready dump. CPU_TRACE_TIMESTAMP_EN prefixes entries with a cycle count.
module cpu_trace_probe #(
  parameter  int XLEN     = 32,
  parameter  int DEPTH    = 64,
  parameter  int POST_MAX = 255,
  localparam int PW       = $clog2(POST_MAX+1),
  localparam int AW       = $clog2(DEPTH),
`ifdef CPU_TRACE_TIMESTAMP_EN
  localparam int DW       = 5*XLEN+5
`else
  localparam int DW       = 4*XLEN+5
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            arm,
  input  logic            abort,
  input  logic            trig_en,
  input  logic [XLEN-1:0] trig_pc,
  input  logic [PW-1:0]   post_cnt,
  input  logic            ret_valid,
  input  logic [XLEN-1:0] ret_pc,
  input  logic [4:0]      ret_rd,
  input  logic [XLEN-1:0] ret_rd_data,
  input  logic [XLEN-1:0] ret_rs1_data,
  input  logic [XLEN-1:0] ret_rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_data,
  output logic            out_last,
  output logic [1:0]      state,
  output logic            triggered,
  output logic            wrapped
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_POST, S_DUMP} state_t;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  state_t          st;
  logic [DW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count, emitted;
  logic [PW-1:0]   post_q, remaining;
  logic            trig_en_q;
  logic [XLEN-1:0] trig_pc_q;
  logic [DW-1:0]   entry;
  logic            capture, full, hit;

  assign state   = st;
  assign capture = ret_valid && !abort && (st == S_ARMED || st == S_POST);
  assign full    = (count == FULL);
  assign hit     = trig_en_q && (ret_pc == trig_pc_q);

`ifdef CPU_TRACE_TIMESTAMP_EN
  logic [XLEN-1:0] ts;
  always_ff @(posedge clk) begin
    if (rst) ts <= '0;
    else     ts <= ts + 1'b1;
  end
  assign entry = {ts, ret_pc, ret_rd, ret_rd_data, ret_rs1_data, ret_rs2_data};
`else
  assign entry = {ret_pc, ret_rd, ret_rd_data, ret_rs1_data, ret_rs2_data};
`endif

  always_ff @(posedge clk) begin
    if (capture) mem[wr_ptr] <= entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= S_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      emitted   <= '0;
      post_q    <= '0;
      remaining <= '0;
      trig_en_q <= 1'b0;
      trig_pc_q <= '0;
      triggered <= 1'b0;
      wrapped   <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else if (abort) begin
      st        <= S_IDLE;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      // rd_ptr always tracks the oldest live entry, so DUMP needs no setup cycle
      if (capture) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (full) begin
          wrapped <= 1'b1;
          rd_ptr  <= wr_ptr + 1'b1;
        end else begin
          count <= count + 1'b1;
        end
      end
      case (st)
        S_IDLE: if (arm) begin
          st        <= S_ARMED;
          wr_ptr    <= '0;
          rd_ptr    <= '0;
          count     <= '0;
          emitted   <= '0;
          triggered <= 1'b0;
          wrapped   <= 1'b0;
          post_q    <= post_cnt;
          trig_en_q <= trig_en;
          trig_pc_q <= trig_pc;
        end
        S_ARMED: if (capture) begin
          if (hit) begin
            triggered <= 1'b1;
            if (post_q == '0) st <= S_DUMP;
            else begin
              st        <= S_POST;
              remaining <= post_q;
            end
          end else if (!trig_en_q && count == FULL - 1'b1) begin
            st <= S_DUMP;
          end
        end
        S_POST: if (capture) begin
          remaining <= remaining - 1'b1;
          if (remaining == PW'(1)) st <= S_DUMP;
        end
        S_DUMP: if (!out_valid || out_ready) begin
          if (emitted != count) begin
            out_data  <= mem[rd_ptr];
            out_valid <= 1'b1;
            out_last  <= (emitted == count - 1'b1);
            rd_ptr    <= rd_ptr + 1'b1;
            emitted   <= emitted + 1'b1;
          end else begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            st        <= S_IDLE;
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_trace_probe.sv
`timescale 1ns/1ps
// Directed bench for cpu_trace_probe: full capture, trigger+wrap, backpressure, abort, sparse retires.
module tb_cpu_trace_probe;
  localparam int XLEN = 32;
  localparam int DEPTH = 64;
  localparam int POST_MAX = 255;
  localparam int PW = 8;
`ifdef CPU_TRACE_TIMESTAMP_EN
  localparam int DW = 5*XLEN+5;
`else
  localparam int DW = 4*XLEN+5;
`endif
  localparam int RW = 4*XLEN+5;

  logic clk = 0, rst = 1, arm = 0, abort = 0, trig_en = 0;
  logic [XLEN-1:0] trig_pc = '0;
  logic [PW-1:0] post_cnt = '0;
  logic ret_valid = 0;
  logic [XLEN-1:0] ret_pc = '0, ret_rd_data = '0, ret_rs1_data = '0, ret_rs2_data = '0;
  logic [4:0] ret_rd = '0;
  logic out_valid, out_ready = 0, out_last, triggered, wrapped;
  logic [DW-1:0] out_data;
  logic [1:0] state;

  int errors = 0, checks = 0;
  logic [RW-1:0] got_rec[$];
  logic got_last[$];
  logic [XLEN-1:0] got_ts[$];

  cpu_trace_probe #(.XLEN(XLEN), .DEPTH(DEPTH), .POST_MAX(POST_MAX)) dut (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort), .trig_en(trig_en), .trig_pc(trig_pc),
    .post_cnt(post_cnt), .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_rd(ret_rd),
    .ret_rd_data(ret_rd_data), .ret_rs1_data(ret_rs1_data), .ret_rs2_data(ret_rs2_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .state(state), .triggered(triggered), .wrapped(wrapped));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [RW-1:0] exp_rec(input logic [XLEN-1:0] pc);
    logic [XLEN-1:0] r1, r2;
    r1 = pc + 32'd1;
    r2 = pc * 32'd3;
    return {pc, pc[6:2], ~pc, r1, r2};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic retire(input logic [XLEN-1:0] pc);
    ret_valid = 1; ret_pc = pc; ret_rd = pc[6:2]; ret_rd_data = ~pc;
    ret_rs1_data = pc + 32'd1; ret_rs2_data = pc * 32'd3;
    tick();
    ret_valid = 0;
  endtask

  task automatic do_arm(input logic te, input logic [XLEN-1:0] tpc, input logic [PW-1:0] pc_n);
    trig_en = te; trig_pc = tpc; post_cnt = pc_n; arm = 1;
    tick();
    arm = 0;
  endtask

  task automatic clear_q();
    got_rec.delete(); got_last.delete(); got_ts.delete();
  endtask

  task automatic collect(input int budget);
    out_ready = 1;
    for (int c = 0; c < budget; c++) begin
      if (out_valid) begin
        got_rec.push_back(out_data[RW-1:0]);
        got_last.push_back(out_last);
        got_ts.push_back(out_data[DW-1 -: XLEN]);
      end
      if (state == 2'd0 && !out_valid) break;
      tick();
    end
    out_ready = 0;
  endtask

  task automatic test_reset();
    tick(); tick();
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d exp 0", state); end
    checks++; if (out_valid !== 1'b0 || out_last !== 1'b0) begin errors++; $display("FAIL reset_out: valid=%b last=%b exp 0 0", out_valid, out_last); end
    checks++; if (triggered !== 1'b0 || wrapped !== 1'b0) begin errors++; $display("FAIL reset_flags: trig=%b wrap=%b exp 0 0", triggered, wrapped); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_data: got %0h exp 0", out_data); end
    rst = 0;
    tick();
  endtask

  task automatic test_full();
    do_arm(1'b0, '0, '0);
    for (int i = 0; i < 64; i++) begin
      retire(32'h100 + 32'(4*i));
      if (i == 62) begin
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL full_armed63: state %0d exp 1", state); end
      end
    end
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL full_dump_entry: state %0d exp 3", state); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_valid_latency: got %b exp 0", out_valid); end
    clear_q();
    collect(300);
    checks++; if (got_rec.size() != 64) begin errors++; $display("FAIL full_count: got %0d exp 64", got_rec.size()); end
    for (int k = 0; k < got_rec.size(); k++) begin
      checks++; if (got_rec[k] !== exp_rec(32'h100 + 32'(4*k))) begin errors++; $display("FAIL full_rec[%0d]: got %0h exp %0h", k, got_rec[k], exp_rec(32'h100 + 32'(4*k))); end
      checks++; if (got_last[k] !== (k == 63)) begin errors++; $display("FAIL full_last[%0d]: got %b exp %b", k, got_last[k], k == 63); end
    end
    checks++; if (wrapped !== 1'b0 || triggered !== 1'b0) begin errors++; $display("FAIL full_flags: wrap=%b trig=%b exp 0 0", wrapped, triggered); end
    checks++; if (state !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL full_end: state=%0d valid=%b exp 0 0", state, out_valid); end
  endtask

  task automatic test_trigger();
    do_arm(1'b1, 32'h200, 8'd3);
    for (int i = 0; i < 200; i++) begin
      retire(32'(4*i));
      if (i == 128) begin
        checks++; if (state !== 2'd2 || triggered !== 1'b1) begin errors++; $display("FAIL trig_post: state=%0d trig=%b exp 2 1", state, triggered); end
      end
      if (i == 130) begin
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL trig_post_hold: state %0d exp 2", state); end
      end
      if (i == 131) begin
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL trig_dump_entry: state %0d exp 3", state); end
      end
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL trig_valid_hold: got %b exp 1", out_valid); end
    checks++; if (wrapped !== 1'b1 || triggered !== 1'b1) begin errors++; $display("FAIL trig_flags: wrap=%b trig=%b exp 1 1", wrapped, triggered); end
    clear_q();
    collect(300);
    checks++; if (got_rec.size() != 64) begin errors++; $display("FAIL trig_count: got %0d exp 64", got_rec.size()); end
    for (int k = 0; k < got_rec.size(); k++) begin
      checks++; if (got_rec[k] !== exp_rec(32'h110 + 32'(4*k))) begin errors++; $display("FAIL trig_rec[%0d]: got %0h exp %0h", k, got_rec[k], exp_rec(32'h110 + 32'(4*k))); end
      checks++; if (got_last[k] !== (k == 63)) begin errors++; $display("FAIL trig_last[%0d]: got %b exp %b", k, got_last[k], k == 63); end
    end
    checks++; if (wrapped !== 1'b1 || triggered !== 1'b1 || state !== 2'd0) begin errors++; $display("FAIL trig_after: wrap=%b trig=%b state=%0d exp 1 1 0", wrapped, triggered, state); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] held;
    do_arm(1'b0, '0, '0);
    for (int i = 0; i < 64; i++) retire(32'h1000 + 32'(4*i));
    clear_q();
    out_ready = 1;
    for (int c = 0; c < 40 && got_rec.size() < 10; c++) begin
      if (out_valid) begin
        got_rec.push_back(out_data[RW-1:0]); got_last.push_back(out_last); got_ts.push_back(out_data[DW-1 -: XLEN]);
      end
      tick();
    end
    out_ready = 0;
    held = out_data;
    for (int s = 0; s < 5; s++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== held) begin errors++; $display("FAIL bp_stall[%0d]: valid=%b data=%0h exp 1 %0h", s, out_valid, out_data, held); end
    end
    checks++; if (held[RW-1:0] !== exp_rec(32'h1028)) begin errors++; $display("FAIL bp_held: got %0h exp %0h", held[RW-1:0], exp_rec(32'h1028)); end
    collect(300);
    checks++; if (got_rec.size() != 64) begin errors++; $display("FAIL bp_count: got %0d exp 64", got_rec.size()); end
    for (int k = 0; k < got_rec.size(); k++) begin
      checks++; if (got_rec[k] !== exp_rec(32'h1000 + 32'(4*k))) begin errors++; $display("FAIL bp_rec[%0d]: got %0h exp %0h", k, got_rec[k], exp_rec(32'h1000 + 32'(4*k))); end
    end
  endtask

  task automatic test_abort();
    retire(32'h50);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL idle_ignore: state %0d exp 0", state); end
    do_arm(1'b1, 32'hFFFF_0000, 8'd4);
    for (int i = 0; i < 10; i++) retire(32'h3000 + 32'(4*i));
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL abort_pre: state %0d exp 1", state); end
    abort = 1; tick(); abort = 0;
    checks++; if (state !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL abort_state: state=%0d valid=%b exp 0 0", state, out_valid); end
    for (int s = 0; s < 4; s++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_quiet[%0d]: valid %b exp 0", s, out_valid); end
    end
    do_arm(1'b1, 32'h40, 8'd0);
    retire(32'h40);
    checks++; if (state !== 2'd3 || triggered !== 1'b1) begin errors++; $display("FAIL single_dump: state=%0d trig=%b exp 3 1", state, triggered); end
    clear_q();
    collect(50);
    checks++; if (got_rec.size() != 1) begin errors++; $display("FAIL single_count: got %0d exp 1", got_rec.size()); end
    if (got_rec.size() >= 1) begin
      checks++; if (got_rec[0] !== exp_rec(32'h40) || got_last[0] !== 1'b1) begin errors++; $display("FAIL single_rec: got %0h last=%b exp %0h 1", got_rec[0], got_last[0], exp_rec(32'h40)); end
    end
    checks++; if (wrapped !== 1'b0 || state !== 2'd0) begin errors++; $display("FAIL single_after: wrap=%b state=%0d exp 0 0", wrapped, state); end
  endtask

  task automatic test_gaps();
    do_arm(1'b1, 32'h2010, 8'd2);
    for (int i = 0; i < 7; i++) begin
      retire(32'h2000 + 32'(4*i));
      if (i < 6) begin tick(); tick(); end
    end
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL gap_dump: state %0d exp 3", state); end
    clear_q();
    collect(60);
    checks++; if (got_rec.size() != 7) begin errors++; $display("FAIL gap_count: got %0d exp 7", got_rec.size()); end
    for (int k = 0; k < got_rec.size(); k++) begin
      checks++; if (got_rec[k] !== exp_rec(32'h2000 + 32'(4*k))) begin errors++; $display("FAIL gap_rec[%0d]: got %0h exp %0h", k, got_rec[k], exp_rec(32'h2000 + 32'(4*k))); end
      checks++; if (got_last[k] !== (k == 6)) begin errors++; $display("FAIL gap_last[%0d]: got %b exp %b", k, got_last[k], k == 6); end
`ifdef CPU_TRACE_TIMESTAMP_EN
      if (k > 0) begin
        checks++; if (got_ts[k] - got_ts[k-1] !== 32'd3) begin errors++; $display("FAIL gap_ts[%0d]: delta %0d exp 3", k, got_ts[k] - got_ts[k-1]); end
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_full();
    test_trigger();
    test_backpressure();
    test_abort();
    test_gaps();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
